// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage.
// One transaction at a time: grant, wait for m_ack or timeout, one-cycle completion pulse.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_type,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_type,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err,
    output logic        err_src,
    output logic [1:0]  fsm_state
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          grant_d;
    logic          timeout_hit;

    // Data wins a contested cycle until it has taken MAX_D_STREAK grants in a row.
    always_comb begin
        grant_d     = d_req && (!if_req || (streak < STREAK_MAX));
        timeout_hit = (tcnt == TO_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            streak   <= '0;
            tcnt     <= '0;
            if_rdata <= '0;
            if_valid <= 1'b0;
            d_rdata  <= '0;
            d_valid  <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_type   <= '0;
            err      <= 1'b0;
            err_src  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= BUSY_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_type  <= d_type;
                        tcnt    <= '0;
                        streak  <= if_req ? streak + 1'b1 : '0;
                    end else if (if_req) begin
                        state   <= BUSY_I;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wdata <= '0;
                        m_type  <= 3'b000;
                        tcnt    <= '0;
                        streak  <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // An ack arriving in the timeout cycle still completes normally.
                    if (m_ack) begin
                        m_req <= 1'b0;
                        state <= DONE;
                        if (state == BUSY_I) begin
                            if_rdata <= m_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            if (!m_we) d_rdata <= m_rdata;
                            d_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        m_req <= 1'b0;
                        state <= DONE;
                        err   <= 1'b1;
                        if (!err) err_src <= (state == BUSY_D);
                        if (state == BUSY_I) begin
                            if_rdata <= 32'hffff_ffff;
                            if_valid <= 1'b1;
                        end else begin
                            d_rdata <= 32'hffff_ffff;
                            d_valid <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign fsm_state = state;

endmodule
